// File: rtl/avalon_pattern_slave_if.sv
// Avalon-MM bus bundle for avalon_pattern_slave: request signals from the
// master, read payload and waitrequest back from the slave.
interface avalon_pattern_slave_if;
    logic [31:0] address;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        waitrequest;

    modport master (
        output address, write, write_data, read,
        input  read_data, waitrequest
    );

    modport slave (
        input  address, write, write_data, read,
        output read_data, waitrequest
    );
endinterface

// File: rtl/avalon_pattern_slave.sv
// Avalon-MM slave with a 4096 x 32 word store, a programmable number of
// waitrequest cycles per transfer, an accepted-write counter and an optional
// data == address pattern checker (enabled by defining PATTERN_CHECK_EN).
// Addresses with any of bits [31:12] set are acknowledged but out of range:
// writes are discarded and reads return 32'hDEADBEEF.
module avalon_pattern_slave #(
    parameter int unsigned WAIT_CYCLES = 1   // 0..15
) (
    input  logic                   clock,
    input  logic                   reset,       // synchronous, active low
    avalon_pattern_slave_if.slave  bus,
    output logic [31:0]            write_count,
    output logic [15:0]            error_count,
    output logic                   pattern_ok
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        cap_write;
    logic        cap_read;
    logic        in_range;
    logic [11:0] word_idx;
    logic [31:0] mem [4096];

    assign in_range = (bus.address[31:12] == 20'd0);
    assign word_idx = bus.address[11:0];

    // Next-state, wait-counter and waitrequest decode; captures only from IDLE.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_next       = state;
        wait_cnt_next    = wait_cnt;
        cap_write        = 1'b0;
        cap_read         = 1'b0;
        bus.waitrequest  = 1'b1;
        case (state)
            IDLE: begin
                if (bus.write || bus.read) begin
                    // Write wins when both strobes are high.
                    cap_write = bus.write;
                    cap_read  = !bus.write;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACK;
                    end else begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ACK;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ACK: begin
                // Requests seen here are dropped; the master waits for this ack.
                bus.waitrequest = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and wait counter registers; reset aborts any transfer in flight.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Word store written at the capture edge; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset so it maps onto RAM and keeps its
        // contents across a reset; only the write enable is reset-qualified.
        if (reset && cap_write && in_range) begin
            mem[word_idx] <= bus.write_data;
        end
    end

    // Read payload latched at capture and held until the next captured read.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.read_data <= 32'd0;
        end else if (cap_read) begin
            bus.read_data <= in_range ? mem[word_idx] : 32'hDEADBEEF;
        end
    end

    // Count of in-range writes accepted, wrapping at 2^32.
    always_ff @(posedge clock) begin
        if (!reset) begin
            write_count <= 32'd0;
        end else if (cap_write && in_range) begin
            write_count <= write_count + 32'd1;
        end
    end

`ifdef PATTERN_CHECK_EN
    // Saturating count of in-range writes whose data differs from the address.
    always_ff @(posedge clock) begin
        if (!reset) begin
            error_count <= 16'd0;
        end else if (cap_write && in_range && (bus.write_data != bus.address)
                     && (error_count != 16'hFFFF)) begin
            error_count <= error_count + 16'd1;
        end
    end

    assign pattern_ok = (error_count == 16'd0);
`else
    assign error_count = 16'd0;
    assign pattern_ok  = 1'b1;
`endif

endmodule

// File: tb/tb_avalon_pattern_slave.sv
// Directed plus randomized bench for avalon_pattern_slave. dut0 runs with
// WAIT_CYCLES=1, dut1 with WAIT_CYCLES=0. Expected values come from a plain
// array model of the word store and counters.
module tb_avalon_pattern_slave;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    avalon_pattern_slave_if bus0 ();
    avalon_pattern_slave_if bus1 ();

    logic [31:0] wc0, wc1;
    logic [15:0] ec0, ec1;
    logic        ok0, ok1;

    avalon_pattern_slave #(.WAIT_CYCLES(1)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus0),
        .write_count (wc0),
        .error_count (ec0),
        .pattern_ok  (ok0)
    );

    avalon_pattern_slave #(.WAIT_CYCLES(0)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus1),
        .write_count (wc1),
        .error_count (ec1),
        .pattern_ok  (ok1)
    );

`ifdef PATTERN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Cycles from the capture edge to the observed ack for dut0.
    localparam int LAT0 = 1 + 1;

    int checks   = 0;
    int failures = 0;

    // Reference model for dut0.
    logic [31:0] m_mem [4096];
    bit          m_valid [4096];
    longint      m_wc = 0;
    int          m_ec = 0;
    logic [31:0] m_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        if (addr < 32'd4096) begin
            m_mem[addr[11:0]]   = data;
            m_valid[addr[11:0]] = 1'b1;
            m_wc = (m_wc + 1) % 64'h1_0000_0000;
            if (CHK && data != addr && m_ec < 65535) m_ec++;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return (addr < 32'd4096) ? m_mem[addr[11:0]] : 32'hDEADBEEF;
    endfunction

    // One single-pulse transfer on dut0, checked against the model.
    task automatic do_op(input string tag, input bit is_write,
                         input logic [31:0] addr, input logic [31:0] data);
        int lat;
        @(negedge clock);
        bus0.address    = addr;
        bus0.write_data = data;
        bus0.write      = is_write;
        bus0.read       = !is_write;
        @(negedge clock);
        bus0.write = 1'b0;
        bus0.read  = 1'b0;
        lat = 1;
        while (bus0.waitrequest !== 1'b0 && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT0));
        if (is_write) model_write(addr, data);
        else          m_rd = model_read(addr);
        check({tag, "_read_data"}, bus0.read_data, m_rd);
        check({tag, "_write_count"}, wc0, m_wc[31:0]);
        check({tag, "_error_count"}, 32'(ec0), 32'(m_ec));
        check({tag, "_pattern_ok"}, 32'(ok0), 32'(m_ec == 0));
        @(negedge clock);
        check({tag, "_ack_one_cycle"}, 32'(bus0.waitrequest), 32'd1);
    endtask

    initial begin
        logic [31:0] a, d, saved_wc;
        int low_cycles;

        bus0.address = '0; bus0.write = 1'b0; bus0.write_data = '0; bus0.read = 1'b0;
        bus1.address = '0; bus1.write = 1'b0; bus1.write_data = '0; bus1.read = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_waitrequest", 32'(bus0.waitrequest), 32'd1);
        check("rst_read_data", bus0.read_data, 32'd0);
        check("rst_write_count", wc0, 32'd0);
        check("rst_error_count", 32'(ec0), 32'd0);
        check("rst_pattern_ok", 32'(ok0), 32'd1);
        check("rst_d1_waitrequest", 32'(bus1.waitrequest), 32'd1);
        check("rst_d1_write_count", wc1, 32'd0);
        reset = 1'b1;

        // Single write addr 5 data 5, then read it back.
        do_op("w5", 1'b1, 32'd5, 32'd5);
        check("w5_count_one", wc0, 32'd1);
        do_op("r5", 1'b0, 32'd5, 32'd0);
        check("r5_value", bus0.read_data, 32'd5);

        // Fill 0..4094 with data == address.
        for (int i = 0; i < 4095; i++) do_op("fill", 1'b1, 32'(i), 32'(i));
        check("fill_error_count", 32'(ec0), 32'd0);
        check("fill_pattern_ok", 32'(ok0), 32'd1);

        // Pattern mismatch at address 7.
        do_op("mis7", 1'b1, 32'd7, 32'd9);
        check("mis7_error_count", 32'(ec0), CHK ? 32'd1 : 32'd0);
        check("mis7_pattern_ok", 32'(ok0), CHK ? 32'd0 : 32'd1);

        // Out-of-range write and read.
        saved_wc = wc0;
        do_op("oor_w", 1'b1, 32'h1000, 32'h1234_5678);
        check("oor_w_count_unchanged", wc0, saved_wc);
        do_op("oor_r", 1'b0, 32'h1000, 32'd0);
        check("oor_r_deadbeef", bus0.read_data, 32'hDEADBEEF);

        // Randomized mix of reads and writes.
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, 4095));
            else if (a[31:12] == 20'd0) a[31] = 1'b1;
            d = ($urandom_range(0, 2) == 0) ? a : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_op("rnd_w", 1'b1, a, d);
            end else begin
                if (a < 32'd4096 && !m_valid[a[11:0]]) a = 32'd5;
                do_op("rnd_r", 1'b0, a, 32'd0);
            end
        end

        // WAIT_CYCLES=0: simultaneous write/read at addr 3, write wins, ack next cycle.
        @(negedge clock);
        bus1.address = 32'd3; bus1.write_data = 32'h3333_0003;
        bus1.write = 1'b1; bus1.read = 1'b1;
        @(negedge clock);
        bus1.write = 1'b0; bus1.read = 1'b0;
        check("d1_ack_next_cycle", 32'(bus1.waitrequest), 32'd0);
        bus1.read = 1'b1;                       // read pulse during ACK
        @(negedge clock);
        bus1.read = 1'b0;
        check("d1_idle_after_ack", 32'(bus1.waitrequest), 32'd1);
        check("d1_write_count", wc1, 32'd1);
        check("d1_error_count", 32'(ec1), CHK ? 32'd1 : 32'd0);
        @(negedge clock);
        check("d1_read_in_ack_ignored", 32'(bus1.waitrequest), 32'd1);
        check("d1_read_data_held", bus1.read_data, 32'd0);
        bus1.read = 1'b1;
        @(negedge clock);
        bus1.read = 1'b0;
        check("d1_read_ack", 32'(bus1.waitrequest), 32'd0);
        check("d1_read_value", bus1.read_data, 32'h3333_0003);

        // Reset asserted while dut0 is in WAIT; a write at the reset edge is dropped.
        @(negedge clock);
        bus0.address = 32'd100; bus0.write_data = 32'hA5A5_0100; bus0.write = 1'b1;
        @(negedge clock);
        bus0.write = 1'b0;
        check("abort_in_wait", 32'(bus0.waitrequest), 32'd1);
        model_write(32'd100, 32'hA5A5_0100);
        reset = 1'b0;
        bus0.address = 32'd200; bus0.write_data = 32'h0BAD_0200; bus0.write = 1'b1;
        @(negedge clock);
        bus0.write = 1'b0;
        reset = 1'b1;
        m_wc = 0; m_ec = 0; m_rd = 32'd0;
        check("abort_waitrequest", 32'(bus0.waitrequest), 32'd1);
        check("abort_write_count", wc0, 32'd0);
        check("abort_error_count", 32'(ec0), 32'd0);
        check("abort_pattern_ok", 32'(ok0), 32'd1);
        check("abort_read_data", bus0.read_data, 32'd0);
        low_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus0.waitrequest === 1'b0) low_cycles++;
        end
        check("abort_no_ack", 32'(low_cycles), 32'd0);
        do_op("keep100", 1'b0, 32'd100, 32'd0);
        do_op("drop200", 1'b0, 32'd200, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_pattern_slave.md
AVALON_PATTERN_SLAVE -- requirements
Module: avalon_pattern_slave

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning the number of waitrequest-high cycles inserted after capture, legal range 0..15.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port address  input  32  Avalon-MM word address from the master.
REQ-005 SHALL have port write  input  1  write request; may be a single-cycle pulse.
REQ-006 SHALL have port write_data  input  32  write payload.
REQ-007 SHALL have port read  input  1  read request; may be a single-cycle pulse.
REQ-008 SHALL have port read_data  output  32  read payload, valid in the cycle waitrequest is low after a read.
REQ-009 SHALL have port waitrequest  output  1  high = busy; low for exactly one cycle to acknowledge a request.
REQ-010 SHALL have port write_count  output  32  number of accepted writes, wraps modulo 2^32.
REQ-011 SHALL have port error_count  output  16  pattern mismatches, saturating.
REQ-012 SHALL have port pattern_ok  output  1  high while error_count is 0.

Function
REQ-013 SHALL contain a 4096 x 32 storage array indexed by address[11:0].
REQ-014 SHALL implement the states IDLE, WAIT and ACK.
REQ-015 IDLE: waitrequest=1; on write=1 capture the request, else on read=1 capture the request; write has priority when both are high.
REQ-016 Capture: with WAIT_CYCLES>0 go to WAIT with the counter loaded with WAIT_CYCLES-1; with WAIT_CYCLES=0 go directly to ACK.
REQ-017 WAIT: waitrequest=1; decrement the counter; go to ACK when the counter is 0.
REQ-018 ACK: waitrequest=0 for exactly one cycle; always return to IDLE; requests presented during ACK are ignored.
REQ-019 Latency: a request captured at edge N SHALL see waitrequest low in cycle N+1+WAIT_CYCLES.
REQ-020 Write in range (address[31:12]==0): store write_data at the capture edge and increment write_count.
REQ-021 Write out of range (address[31:12]!=0): discard the data, do not increment write_count, and still acknowledge it.
REQ-022 Read in range: latch the array word into read_data at the capture edge; out of range: read_data=32'hDEADBEEF.
REQ-023 read_data SHALL hold its value until the next captured read.
REQ-024 Requests arriving in WAIT or ACK SHALL be dropped; the master holds off until acknowledged.

Reset
REQ-025 While reset=0 at an edge: state=IDLE, waitrequest=1, read_data=0, write_count=0, error_count=0, pattern_ok=1, wait counter=0.
REQ-026 Reset mid-transaction SHALL abort it with no ACK cycle; the array contents are not cleared.
REQ-027 A write captured at the same edge where reset=0 SHALL NOT be stored.

Configuration
REQ-028 Macro PATTERN_CHECK_EN defined: for each in-range accepted write with write_data != address, increment error_count, saturating at 16'hFFFF; pattern_ok = (error_count==0).
REQ-029 Macro PATTERN_CHECK_EN undefined: no compare logic; error_count tied to 0; pattern_ok tied to 1.

Verification
REQ-030 WAIT_CYCLES=1, write pulse addr=5 data=5 -> waitrequest low exactly 2 cycles later for 1 cycle; write_count=1; later read addr 5 returns 5.
REQ-031 Writes 0..4094 with data=addr, back-to-back per handshake -> write_count=4095, error_count=0, pattern_ok=1 (macro on).
REQ-032 Write addr=7 data=9 with macro on -> error_count=1, pattern_ok=0; macro off -> error_count=0, pattern_ok=1.
REQ-033 Write addr=32'h1000 -> acknowledged, write_count unchanged; read addr=32'h1000 -> read_data=32'hDEADBEEF.
REQ-034 WAIT_CYCLES=0, write and read high together at addr=3 -> write wins, ACK at N+1; a read pulse during ACK is ignored.
REQ-035 reset=0 asserted in WAIT -> next cycle IDLE, waitrequest=1, no ACK pulse, counters=0, array contents retained.
